// File: rtl/wb_tagged_ram.sv
// Wishbone B4 classic-cycle RAM slave with a 4-bit tag per 32-bit word.
// Byte/half/word/tag accesses are selected by SEL_I; data is right-justified on the bus.
module wb_tagged_ram #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1,
    parameter int TAG_ENABLE  = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        ERR_O
);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            off_q, off_d;
    logic [3:0]            sel_q, sel_d;
    logic                  we_q, we_d;
    logic [31:0]           wdat_q, wdat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_q, dat_d;

    logic [31:0]           mem_q [DEPTH];
    logic [3:0]            tag_q [DEPTH];

    logic [ADDR_WIDTH-1:0] req_idx;
    logic [1:0]            req_off;
    logic [3:0]            req_sel;
    logic                  req_we;
    logic [31:0]           req_wdat;
    logic                  req_legal;
    logic                  req_tag;
    logic                  do_resp;
    logic                  mem_we;
    logic                  tag_we;
    logic [31:0]           cur_word;
    logic [3:0]            cur_tag;
    logic [31:0]           new_word;
    logic [31:0]           rd_word;
    logic                  unused_adr;

    assign unused_adr = &{1'b0, ADR_I[31:ADDR_WIDTH+2]};

    // With zero wait states the response happens on the sampling edge, so the live bus is used.
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_idx  = ADR_I[ADDR_WIDTH+1:2];
            req_off  = ADR_I[1:0];
            req_sel  = SEL_I;
            req_we   = WE_I;
            req_wdat = DAT_I;
        end else begin
            req_idx  = idx_q;
            req_off  = off_q;
            req_sel  = sel_q;
            req_we   = we_q;
            req_wdat = wdat_q;
        end
    end

    always_comb begin
        req_tag   = (req_sel == 4'b0101);
        req_legal = 1'b0;
        case (req_sel)
            4'b1111: req_legal = (req_off == 2'b00);
            4'b0011: req_legal = ~req_off[0];
            4'b0001: req_legal = 1'b1;
            4'b0101: req_legal = (TAG_ENABLE != 0);
            default: req_legal = 1'b0;
        endcase
    end

    always_comb begin
        cur_word = mem_q[req_idx];
        cur_tag  = tag_q[req_idx];
        new_word = cur_word;
        rd_word  = cur_word;
        case (req_sel)
            4'b0011: begin
                new_word[{req_off[1], 4'b0000} +: 16] = req_wdat[15:0];
                rd_word = {16'b0, cur_word[{req_off[1], 4'b0000} +: 16]};
            end
            4'b0001: begin
                new_word[{req_off, 3'b000} +: 8] = req_wdat[7:0];
                rd_word = {24'b0, cur_word[{req_off, 3'b000} +: 8]};
            end
            4'b0101: rd_word = {28'b0, cur_tag};
            default: new_word = req_wdat;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        do_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CYC_I && STB_I) begin
                    idx_d  = ADR_I[ADDR_WIDTH+1:2];
                    off_d  = ADR_I[1:0];
                    sel_d  = SEL_I;
                    we_d   = WE_I;
                    wdat_d = DAT_I;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        do_resp = 1'b1;
                    end else begin
                        cnt_d   = WS_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!CYC_I) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                    do_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // The RESP cycle never samples the bus, so a held STB is not acknowledged twice.
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (do_resp) begin
            if (req_legal) begin
                ack_d = 1'b1;
                if (!req_we) dat_d = rd_word;
            end else begin
                err_d = 1'b1;
                dat_d = 32'd0;
            end
        end
        mem_we = do_resp && req_legal && req_we && !req_tag;
        tag_we = do_resp && req_legal && req_we && req_tag;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            wdat_q  <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // Storage arrays carry no reset; contents survive RST_I.
    always_ff @(posedge CLK_I) begin
        if (mem_we) mem_q[req_idx] <= new_word;
        if (tag_we) tag_q[req_idx] <= req_wdat[3:0];
    end

    assign DAT_O = dat_q;
    assign ACK_O = ack_q;
    assign ERR_O = err_q;
endmodule
